// File: rtl/manta_pkg.sv
// manta_pkg: capture-controller state encoding and register offsets, shared with the
// host-side register map.
package manta_pkg;
    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        MOVE_TO_POSITION = 3'd1,
        IN_POSITION      = 3'd2,
        CAPTURING        = 3'd3,
        CAPTURED         = 3'd4
    } cap_state_t;

    localparam logic [15:0] REG_STATE     = 16'd0;
    localparam logic [15:0] REG_TRIG_LOC  = 16'd1;
    localparam logic [15:0] REG_START     = 16'd2;
    localparam logic [15:0] REG_STOP      = 16'd3;
    localparam logic [15:0] REG_WRITE_PTR = 16'd4;
    localparam logic [15:0] REG_READ_PTR  = 16'd5;

    function automatic logic is_writing(cap_state_t s);
        return s == MOVE_TO_POSITION || s == IN_POSITION || s == CAPTURING;
    endfunction
endpackage

// File: rtl/capture_controller.sv
// capture_controller: logic-analyzer capture sequencer with a bus-mapped register file
// in a registered passthrough bus chain; drives write side of an external sample memory.
module capture_controller
    import manta_pkg::*;
#(
    parameter int BASE_ADDR    = 0,
    parameter int SAMPLE_DEPTH = 1024,
    localparam int AW = $clog2(SAMPLE_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trig,
    output logic [AW-1:0] bram_addr_o,
    output logic          bram_we_o,
    input  logic [15:0]   addr_i,
    input  logic [15:0]   wdata_i,
    input  logic [15:0]   rdata_i,
    input  logic          rw_i,
    input  logic          valid_i,
    output logic [15:0]   addr_o,
    output logic [15:0]   wdata_o,
    output logic [15:0]   rdata_o,
    output logic          rw_o,
    output logic          valid_o
);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(SAMPLE_DEPTH);

    cap_state_t    r_state;
    cap_state_t    w_state_nxt;
    logic [AW-1:0] r_tloc;
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW-1:0] w_wp_inc;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] w_post;
    logic [16:0]   w_diff;
    logic [15:0]   w_off;
    logic [15:0]   w_rd_val;
    logic          w_hit;
    logic          w_wr;
    logic          w_rd_hit;
    logic          w_start;
    logic          w_stop;
    logic          w_tloc_wr;
    logic          w_done;

    // 17-bit subtract so addresses below BASE_ADDR show up as a borrow
    assign w_diff    = {1'b0, addr_i} - 17'(BASE_ADDR);
    assign w_off     = w_diff[15:0];
    assign w_hit     = valid_i && !w_diff[16] && w_off <= REG_READ_PTR;
    assign w_wr      = w_hit && rw_i;
    assign w_start   = w_wr && w_off == REG_START && wdata_i == 16'd1;
    assign w_stop    = w_wr && w_off == REG_STOP && wdata_i == 16'd1;
    assign w_tloc_wr = w_wr && w_off == REG_TRIG_LOC && {1'b0, wdata_i} < 17'(SAMPLE_DEPTH)
                       && (r_state == IDLE || r_state == CAPTURED);
    assign w_rd_hit  = w_hit && !rw_i && w_off != REG_START && w_off != REG_STOP;
    assign w_rd_val  = w_off == REG_STATE     ? 16'(r_state) :
                       w_off == REG_TRIG_LOC  ? 16'(r_tloc)  :
                       w_off == REG_WRITE_PTR ? 16'(r_wp)    : 16'(r_rp);

    assign bram_we_o   = is_writing(r_state);
    assign bram_addr_o = r_wp;
    assign w_wp_inc    = r_wp + AW'(1);
    assign w_cnt_inc   = r_cnt + CW'(1);
    // samples from the trigger sample through the end of the capture
    assign w_post      = DEPTH - CW'(r_tloc);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = r_cnt;
                if (w_start) begin
                    w_state_nxt = r_tloc == '0 ? IN_POSITION : MOVE_TO_POSITION;
                    w_cnt_nxt   = '0;
                end
            end
            MOVE_TO_POSITION: begin
                if (w_cnt_inc == CW'(r_tloc))
                    w_state_nxt = IN_POSITION;
            end
            IN_POSITION: begin
                w_cnt_nxt = CW'(1);
                if (trig) begin
                    w_done      = w_post == CW'(1);
                    w_state_nxt = w_done ? CAPTURED : CAPTURING;
                end
            end
            CAPTURING: begin
                w_done = w_cnt_inc == w_post;
                if (w_done)
                    w_state_nxt = CAPTURED;
            end
            default: w_cnt_nxt = r_cnt;
        endcase
        if (w_stop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tloc  <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            addr_o  <= '0;
            wdata_o <= '0;
            rdata_o <= '0;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stop || (r_state == IDLE && w_start))
                r_wp <= '0;
            else if (bram_we_o)
                r_wp <= w_wp_inc;
            if (w_tloc_wr)
                r_tloc <= wdata_i[AW-1:0];
            // after a full lap the next write slot holds the oldest sample
            if (w_done && !w_stop)
                r_rp <= w_wp_inc;
            addr_o  <= addr_i;
            wdata_o <= wdata_i;
            rw_o    <= rw_i;
            valid_o <= valid_i;
            rdata_o <= w_rd_hit ? w_rd_val : rdata_i;
        end
    end
endmodule

// File: tb/tb_capture_controller.sv
// tb_capture_controller: directed scenarios with literal expectations plus a per-cycle
// comparison against a sample-count behavioural model of the capture sequence.
module tb_capture_controller;
    localparam int D    = 8;
    localparam int AW   = 3;
    localparam int BASE = 'h40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trig = 1'b0;
    logic [AW-1:0] bram_addr_o;
    logic          bram_we_o;
    logic [15:0]   addr_i = '0;
    logic [15:0]   wdata_i = '0;
    logic [15:0]   rdata_i = 16'hBEEF;
    logic          rw_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [15:0]   addr_o;
    logic [15:0]   wdata_o;
    logic [15:0]   rdata_o;
    logic          rw_o;
    logic          valid_o;

    int passed = 0;
    int total = 0;
    bit armed = 0;
    int wcnt = 0;
    logic [AW-1:0] wq[$];

    capture_controller #(.BASE_ADDR(BASE), .SAMPLE_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig),
        .bram_addr_o(bram_addr_o), .bram_we_o(bram_we_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            passed++;
    endtask

    // Model: mode 0..4 as the visible state register, with sample budgets counted down.
    int m_mode, m_tloc, m_wp, m_rp, m_pre, m_post;
    logic [15:0] m_addr_o, m_wdata_o, m_rdata_o;
    logic m_rw_o, m_valid_o;

    function automatic bit is_wr(int off, int val);
        return valid_i && rw_i && (int'(addr_i) - BASE == off) && int'(wdata_i) == val;
    endfunction

    function automatic logic [15:0] model_rd();
        int off = int'(addr_i) - BASE;
        if (!valid_i || rw_i) return rdata_i;
        case (off)
            0: return 16'(m_mode);
            1: return 16'(m_tloc);
            4: return 16'(m_wp);
            5: return 16'(m_rp);
            default: return rdata_i;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_tloc <= 0; m_wp <= 0; m_rp <= 0; m_pre <= 0; m_post <= 0;
            m_addr_o <= '0; m_wdata_o <= '0; m_rdata_o <= '0; m_rw_o <= 1'b0; m_valid_o <= 1'b0;
        end else begin
            m_addr_o <= addr_i; m_wdata_o <= wdata_i; m_rw_o <= rw_i; m_valid_o <= valid_i;
            m_rdata_o <= model_rd();
            if (valid_i && rw_i && int'(addr_i) - BASE == 1 && int'(wdata_i) < D && (m_mode == 0 || m_mode == 4))
                m_tloc <= int'(wdata_i);
            if (is_wr(3, 1)) begin
                m_mode <= 0; m_wp <= 0;
            end else begin
                if (m_mode >= 1 && m_mode <= 3) m_wp <= (m_wp + 1) % D;
                case (m_mode)
                    0: if (is_wr(2, 1)) begin
                        m_wp <= 0; m_pre <= m_tloc; m_mode <= (m_tloc == 0) ? 2 : 1;
                    end
                    1: begin
                        m_pre <= m_pre - 1;
                        if (m_pre == 1) m_mode <= 2;
                    end
                    2: if (trig) begin
                        m_post <= D - m_tloc - 1;
                        if (D - m_tloc == 1) begin m_mode <= 4; m_rp <= (m_wp + 1) % D; end
                        else m_mode <= 3;
                    end
                    3: begin
                        m_post <= m_post - 1;
                        if (m_post == 1) begin m_mode <= 4; m_rp <= (m_wp + 1) % D; end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("bram_we", bram_we_o, (m_mode >= 1 && m_mode <= 3));
            check("bram_addr", bram_addr_o, m_wp);
            check("bus_out", {addr_o, wdata_o, rdata_o, rw_o, valid_o},
                  {m_addr_o, m_wdata_o, m_rdata_o, m_rw_o, m_valid_o});
        end
        if (bram_we_o) begin
            wcnt++;
            wq.push_back(bram_addr_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int off, input int val);
        addr_i = 16'(BASE + off); wdata_i = 16'(val); rw_i = 1'b1; valid_i = 1'b1;
        tick();
        valid_i = 1'b0; rw_i = 1'b0;
    endtask

    task automatic bus_read(input string name, input int a, input int exp);
        addr_i = 16'(a); rw_i = 1'b0; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check(name, rdata_o, exp);
    endtask

    task automatic rd(input string name, input int off, input int exp);
        bus_read(name, BASE + off, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        armed = 1;
        #1;
        check("rst_we", bram_we_o, 0);
        check("rst_valid_o", valid_o, 0);
        rst_n = 1'b1;
        tick();
        rd("rst_state", 0, 0);
        rd("rst_tloc", 1, 0);
        rd("rst_wp", 4, 0);
        rd("rst_rp", 5, 0);
        bus_read("below_base", BASE - 1, 'hBEEF);
        rdata_i = 16'h1234;
        rd("wo_start_read", 2, 'h1234);
        rd("unmapped6", 6, 'h1234);

        // trigger_loc=3, trig 5 cycles into IN_POSITION
        bus_write(1, 3);
        rd("tloc3", 1, 3);
        bus_write(2, 1);
        check("move_we", bram_we_o, 1);
        check("move_addr0", bram_addr_o, 0);
        repeat (3) tick();
        check("inpos_addr", bram_addr_o, 3);
        repeat (5) tick();
        check("trig_addr", bram_addr_o, 0);
        trig = 1'b1;
        wcnt = 0;
        tick();
        trig = 1'b0;
        repeat (4) tick();
        check("cap_we", bram_we_o, 0);
        check("post_writes", wcnt, 5);
        rd("cap_state", 0, 4);
        rd("cap_wp", 4, 5);
        rd("cap_rp", 5, 5);
        bus_write(1, 9);
        rd("tloc_oob_ignored", 1, 3);
        bus_write(2, 1);
        rd("start_ignored", 0, 4);
        bus_write(3, 1);
        rd("stop_state", 0, 0);
        rd("stop_wp", 4, 0);
        rd("stop_rp_held", 5, 5);

        // trigger_loc=0, trig held high
        bus_write(1, 0);
        wq.delete();
        trig = 1'b1;
        bus_write(2, 1);
        repeat (8) tick();
        trig = 1'b0;
        check("tl0_writes", wq.size(), 8);
        for (int i = 0; i < 8 && i < wq.size(); i++)
            check($sformatf("tl0_addr%0d", i), wq[i], i);
        rd("tl0_state", 0, 4);
        rd("tl0_wp", 4, 0);
        rd("tl0_rp", 5, 0);
        bus_write(3, 1);

        // trig high throughout MOVE_TO_POSITION, trigger_loc write while CAPTURING
        bus_write(1, 4);
        trig = 1'b1;
        bus_write(2, 1);
        rd("move_state", 0, 1);
        repeat (3) tick();
        check("tl4_inpos_addr", bram_addr_o, 4);
        rd("tl4_inpos_state", 0, 2);
        rd("tl4_capt_state", 0, 3);
        bus_write(1, 5);
        rd("tloc_capt_ignored", 1, 4);
        trig = 1'b0;
        rd("tl4_done_state", 0, 4);
        rd("tl4_wp", 4, 0);
        bus_write(3, 1);

        // stop coinciding with trig in IN_POSITION
        bus_write(2, 1);
        repeat (5) tick();
        trig = 1'b1;
        bus_write(3, 1);
        trig = 1'b0;
        check("stop_trig_we", bram_we_o, 0);
        rd("stop_trig_state", 0, 0);
        rd("stop_trig_wp", 4, 0);

        // reset mid-capture
        bus_write(1, 2);
        bus_write(2, 1);
        repeat (3) tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        check("pre_reset_we", bram_we_o, 1);
        #2;
        rst_n = 1'b0;
        wcnt = 0;
        #1;
        check("areset_we", bram_we_o, 0);
        check("areset_addr", bram_addr_o, 0);
        check("areset_bus", {valid_o, rdata_o}, 0);
        tick();
        rst_n = 1'b1;
        rd("post_rst_state", 0, 0);
        rd("post_rst_tloc", 1, 0);
        rd("post_rst_wp", 4, 0);
        rd("post_rst_rp", 5, 0);
        check("no_writes_after_reset", wcnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/capture_controller.md
CAPTURE_CONTROLLER -- requirements
Module: capture_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 0, first bus address decoded by this block.
REQ-002 SHALL have parameter SAMPLE_DEPTH, default 1024, sample memory depth, power of two, 2 to 32768.
REQ-003 SHALL have localparam AW = $clog2(SAMPLE_DEPTH), sample address width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
REQ-005 SHALL have the following trigger and memory-side ports:
- trig  in  1  trigger from trigger block, sampled each cycle
- bram_addr_o  out  AW  sample memory write address
- bram_we_o  out  1  sample memory write enable
REQ-006 SHALL have the following bus-in ports:
- addr_i  in  16  bus address
- wdata_i  in  16  bus write data
- rdata_i  in  16  bus read data passed through
- rw_i  in  1  bus direction, 1 = write
- valid_i  in  1  bus valid
REQ-007 SHALL have the following bus-out ports, all registered: addr_o, wdata_o, rdata_o (16 each); rw_o, valid_o (1 each).

Function
REQ-008 Bus passthrough SHALL have one cycle latency; rdata_o = rdata_i unless this block answers a read.
REQ-009 Register map, offset from BASE_ADDR; reads of unmapped offsets SHALL pass rdata_i unchanged:
- +0 state, RO
- +1 trigger_loc, RW
- +2 request_start, WO
- +3 request_stop, WO
- +4 write_pointer, RO
- +5 read_pointer, RO
REQ-010 Read data SHALL be zero-extended to 16 bits.
REQ-011 States SHALL be encoded as IDLE=0, MOVE_TO_POSITION=1, IN_POSITION=2, CAPTURING=3, CAPTURED=4.
REQ-012 A write of 1 to request_start in IDLE SHALL clear write_pointer and the sample counter, then enter MOVE_TO_POSITION on the next edge, or IN_POSITION directly if trigger_loc=0; in any other state the write SHALL be ignored.
REQ-013 In MOVE_TO_POSITION, IN_POSITION and CAPTURING, bram_we_o SHALL be 1 and bram_addr_o SHALL equal write_pointer, which increments by 1 per cycle and wraps from SAMPLE_DEPTH-1 to 0.
REQ-014 MOVE_TO_POSITION SHALL transition to IN_POSITION after exactly trigger_loc samples have been written; trig SHALL be ignored in this state.
REQ-015 IN_POSITION SHALL write circularly and, on trig=1, enter CAPTURING; the sample written in that trig cycle is the trigger sample.
REQ-016 CAPTURING SHALL write exactly SAMPLE_DEPTH-trigger_loc samples in total, trigger sample included, then enter CAPTURED.
REQ-017 In CAPTURED, bram_we_o SHALL be 0 and read_pointer SHALL equal write_pointer, the address of the oldest sample.
REQ-018 A write of 1 to request_stop SHALL force IDLE from any state on the next edge, with bram_we_o=0 and write_pointer=0.
REQ-019 If request_stop coincides with trig or with a capture-complete edge, stop SHALL win.
REQ-020 trigger_loc writes SHALL take effect only in IDLE or CAPTURED; values >= SAMPLE_DEPTH SHALL be ignored, keeping the old value.
REQ-021 In IDLE, bram_we_o SHALL be 0 and the pointers SHALL hold their values.

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE; trigger_loc=0; write_pointer=0; read_pointer=0; sample counter=0; bram_we_o=0; bram_addr_o=0; all bus outputs=0.
REQ-023 Reset asserted mid-capture SHALL abort the capture with no further memory writes.

Structure
REQ-024 State encoding and register offsets SHALL live in the shared package (manta_pkg) for use by the host-side register map.
REQ-025 The block SHALL be a single module with no sub-modules; the sample memory is external.

Verification
REQ-026 Scenario: SAMPLE_DEPTH=8, trigger_loc=3, start, trig asserted 5 cycles after IN_POSITION entry -> exactly 5 more writes after trig cycle incl. trigger sample (5 total), CAPTURED, read_pointer=write_pointer.
REQ-027 Scenario: trigger_loc=0, start -> IN_POSITION on next edge; trig held 1 -> 8 writes at addrs 0..7, CAPTURED, write_pointer=0.
REQ-028 Scenario: trig=1 throughout MOVE_TO_POSITION (trigger_loc=4) -> no transition before 4 writes; CAPTURING entered on first IN_POSITION cycle.
REQ-029 Scenario: request_stop in same cycle as trig in IN_POSITION -> IDLE, bram_we_o=0, state read returns 0.
REQ-030 Scenario: write trigger_loc=9 (depth 8), then write 5 while CAPTURING -> reads return the prior value both times.
REQ-031 Scenario: rst_n low mid-CAPTURING -> bram_we_o=0 immediately, all registers read reset values.
